saver_sd_card: RTL and testbench



---
 rtl/saver_sd_pkg.sv | 30 +++
 rtl/sector_buf_512x8.sv | 31 +++
 rtl/saver_sd_card.sv | 221 ++++++++++++++++++++++
 tb/tb_saver_sd_card.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/saver_sd_pkg.sv
// rtl/saver_sd_pkg.sv - shared state codes, slot codes and sector geometry for the SD saver
package saver_sd_pkg;

    localparam int SECTOR_BYTES = 512;

    typedef logic [2:0] state_t;

    localparam state_t IDLE      = 3'd0;
    localparam state_t FILL      = 3'd1;
    localparam state_t ISSUE     = 3'd2;
    localparam state_t WAIT_BUSY = 3'd3;
    localparam state_t WAIT_DONE = 3'd4;
    localparam state_t NEXT      = 3'd5;
    localparam state_t FINISH    = 3'd6;

    localparam logic [2:0] SLOT_C1541 = 3'd0;
    localparam logic [2:0] SLOT_CRT   = 3'd1;
    localparam logic [2:0] SLOT_PRG   = 3'd2;
    localparam logic [2:0] SLOT_BIN   = 3'd3;
    localparam logic [2:0] SLOT_TAP   = 3'd4;

    // Slot n owns bit n-1 of the SD controller's write request; the disk slot never writes.
    function automatic logic [3:0] slot_onehot(input logic [2:0] slot);
        if (slot == SLOT_C1541) begin
            return 4'b0000;
        end
        return 4'b0001 << (slot - 3'd1);
    endfunction

endpackage

// File: rtl/sector_buf_512x8.sv
// rtl/sector_buf_512x8.sv - one-sector dual-port buffer, write port A, registered read port B
module sector_buf_512x8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       we_a,
    input  logic [8:0] addr_a,
    input  logic [7:0] din_a,
    input  logic       re_b,
    input  logic [8:0] addr_b,
    output logic [7:0] dout_b
);

    logic [7:0] mem [512];

    // Port A: bytes arriving from the core (or pad bytes)
    always_ff @(posedge clk) begin
        if (we_a) begin
            mem[addr_a] <= din_a;
        end
    end

    // Port B: registered read for the SD controller, output register cleared on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_b <= 8'h00;
        end else if (re_b) begin
            dout_b <= mem[addr_b];
        end
    end

endmodule

// File: rtl/saver_sd_card.sv
// rtl/saver_sd_card.sv - streams a core memory region into a mounted SD image; SAVE_SD_TIMEOUT_EN adds an sd_done watchdog
module saver_sd_card
    import saver_sd_pkg::*;
#(
    parameter logic [7:0]  PAD_BYTE       = 8'h00,
    parameter logic [4:0]  CORE_WAIT      = 5'd31,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
) (
    input  logic        clk,
    input  logic        system_reset,
    input  logic        save_req,
    input  logic [2:0]  save_slot,
    input  logic [22:0] save_len,
    input  logic [4:0]  sd_img_mounted,
    input  logic [31:0] sd_img_size,
    output logic [31:0] sd_lba,
    output logic [3:0]  sd_wr,
    input  logic        sd_busy,
    input  logic [8:0]  sd_byte_index,
    output logic [7:0]  sd_wr_data,
    input  logic        sd_done,
    output logic        ioctl_upload,
    output logic [22:0] ioctl_addr,
    output logic        ioctl_rd,
    input  logic [7:0]  ioctl_din,
    input  logic        ioctl_wait,
    output logic        saver_busy,
    output logic        save_done,
    output logic        save_error
);

`ifdef SAVE_SD_TIMEOUT_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    state_t      state;
    logic [2:0]  slot;
    logic [22:0] len;
    logic [8:0]  cnt;
    logic [4:0]  wcnt;
    logic        rd_d1;
    logic        rd_d2;
    logic [3:0]  sd_wr_r;
    logic [31:0] wd_cnt;
    logic [7:0]  present;
    logic [22:0] size_tab [8];

    logic        in_flight;
    logic        rd_go;
    logic        pad_go;
    logic        buf_we;
    logic [7:0]  buf_din;
    logic        sd_rd_en;
    logic        req_ok;
    logic        size_bad;
    logic        wd_fire;

    // A read is in flight from the strobe until its byte is captured two cycles later.
    assign in_flight = ioctl_rd | rd_d1 | rd_d2;
    assign rd_go     = (state == FILL) && (wcnt == CORE_WAIT) && !ioctl_wait && !in_flight && (ioctl_addr != len);
    assign pad_go    = (state == FILL) && !in_flight && (ioctl_addr == len);
    assign buf_we    = (state == FILL) && (rd_d2 || pad_go);
    assign buf_din   = rd_d2 ? ioctl_din : PAD_BYTE;
    assign sd_rd_en  = (state == WAIT_BUSY) || (state == WAIT_DONE);
    assign req_ok    = (save_slot inside {SLOT_CRT, SLOT_PRG, SLOT_BIN, SLOT_TAP}) && present[save_slot]
                       && (save_len != 23'd0) && (save_len <= size_tab[save_slot]);
    assign size_bad  = !present[slot] || (len > size_tab[slot]);
    assign wd_fire   = WD_EN && sd_rd_en && (wd_cnt == TIMEOUT_CYCLES - 32'd1);

    // The request is dropped combinationally so the controller never sees a second accept.
    assign sd_wr = sd_busy ? 4'b0000 : sd_wr_r;

    sector_buf_512x8 u_buf (
        .clk    (clk),
        .rst    (system_reset),
        .we_a   (buf_we),
        .addr_a (cnt),
        .din_a  (buf_din),
        .re_b   (sd_rd_en),
        .addr_b (sd_byte_index),
        .dout_b (sd_wr_data)
    );

    // Mount table: presence and size per slot, updated on every mount strobe
    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            present <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                size_tab[i] <= 23'd0;
            end
        end else begin
            for (int i = 0; i < 5; i++) begin
                if (sd_img_mounted[i]) begin
                    present[i]  <= |sd_img_size;
                    size_tab[i] <= sd_img_size[22:0];
                end
            end
        end
    end

    // Save sequencer: fill one sector from the core, hand it to the SD controller, repeat
    always_ff @(posedge clk or posedge system_reset) begin
        if (system_reset) begin
            state        <= IDLE;
            slot         <= 3'd0;
            len          <= 23'd0;
            cnt          <= 9'd0;
            wcnt         <= 5'd0;
            rd_d1        <= 1'b0;
            rd_d2        <= 1'b0;
            sd_wr_r      <= 4'b0000;
            wd_cnt       <= 32'd0;
            sd_lba       <= 32'd0;
            ioctl_upload <= 1'b0;
            ioctl_addr   <= 23'd0;
            ioctl_rd     <= 1'b0;
            saver_busy   <= 1'b0;
            save_done    <= 1'b0;
            save_error   <= 1'b0;
        end else begin
            save_done  <= 1'b0;
            save_error <= 1'b0;
            ioctl_rd   <= rd_go;
            rd_d1      <= ioctl_rd;
            rd_d2      <= rd_d1;

            if (rd_go) begin
                wcnt <= 5'd0;
            end else if (wcnt != CORE_WAIT) begin
                wcnt <= wcnt + 5'd1;
            end

            if (sd_rd_en && !wd_fire) begin
                wd_cnt <= wd_cnt + 32'd1;
            end else begin
                wd_cnt <= 32'd0;
            end

            case (state)
                IDLE: begin
                    if (save_req) begin
                        if (req_ok) begin
                            state        <= FILL;
                            slot         <= save_slot;
                            len          <= save_len;
                            cnt          <= 9'd0;
                            ioctl_addr   <= 23'd0;
                            sd_lba       <= 32'd0;
                            ioctl_upload <= 1'b1;
                            saver_busy   <= 1'b1;
                        end else begin
                            save_error <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (buf_we) begin
                        cnt <= cnt + 9'd1;
                        if (rd_d2) begin
                            ioctl_addr <= ioctl_addr + 23'd1;
                        end
                        if (cnt == 9'(SECTOR_BYTES - 1)) begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    sd_wr_r <= slot_onehot(slot);
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (wd_fire) begin
                        sd_wr_r      <= 4'b0000;
                        ioctl_upload <= 1'b0;
                        saver_busy   <= 1'b0;
                        save_error   <= 1'b1;
                        state        <= IDLE;
                    end else if (sd_busy) begin
                        sd_wr_r <= 4'b0000;
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (wd_fire) begin
                        ioctl_upload <= 1'b0;
                        saver_busy   <= 1'b0;
                        save_error   <= 1'b1;
                        state        <= IDLE;
                    end else if (sd_done) begin
                        state <= NEXT;
                    end
                end
                NEXT: begin
                    if (size_bad) begin
                        ioctl_upload <= 1'b0;
                        saver_busy   <= 1'b0;
                        save_error   <= 1'b1;
                        state        <= IDLE;
                    end else if (ioctl_addr == len) begin
                        state <= FINISH;
                    end else begin
                        sd_lba <= sd_lba + 32'd1;
                        state  <= FILL;
                    end
                end
                FINISH: begin
                    ioctl_upload <= 1'b0;
                    saver_busy   <= 1'b0;
                    save_done    <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_saver_sd_card.sv
// tb/tb_saver_sd_card.sv - scoreboard bench for saver_sd_card with a core memory model and an SD controller model
module tb_saver_sd_card;

    localparam logic [7:0] PAD = 8'h00;

    logic        clk = 1'b0;
    logic        system_reset;
    logic        save_req;
    logic [2:0]  save_slot;
    logic [22:0] save_len;
    logic [4:0]  sd_img_mounted;
    logic [31:0] sd_img_size;
    logic [31:0] sd_lba;
    logic [3:0]  sd_wr;
    logic        sd_busy;
    logic [8:0]  sd_byte_index;
    logic [7:0]  sd_wr_data;
    logic        sd_done;
    logic        ioctl_upload;
    logic [22:0] ioctl_addr;
    logic        ioctl_rd;
    logic [7:0]  ioctl_din = 8'h00;
    logic        ioctl_wait;
    logic        saver_busy;
    logic        save_done;
    logic        save_error;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_q [$];
    int          rd_count = 0;
    int          spacing_bad = 0;
    int          since_rd = 0;
    int          rd_stage = 0;
    logic [22:0] rd_addr_q = 23'd0;

    always #5 clk = ~clk;

    saver_sd_card #(
        .PAD_BYTE       (8'h00),
        .CORE_WAIT      (5'd31),
        .TIMEOUT_CYCLES (32'd1000)
    ) dut (
        .clk            (clk),
        .system_reset   (system_reset),
        .save_req       (save_req),
        .save_slot      (save_slot),
        .save_len       (save_len),
        .sd_img_mounted (sd_img_mounted),
        .sd_img_size    (sd_img_size),
        .sd_lba         (sd_lba),
        .sd_wr          (sd_wr),
        .sd_busy        (sd_busy),
        .sd_byte_index  (sd_byte_index),
        .sd_wr_data     (sd_wr_data),
        .sd_done        (sd_done),
        .ioctl_upload   (ioctl_upload),
        .ioctl_addr     (ioctl_addr),
        .ioctl_rd       (ioctl_rd),
        .ioctl_din      (ioctl_din),
        .ioctl_wait     (ioctl_wait),
        .saver_busy     (saver_busy),
        .save_done      (save_done),
        .save_error     (save_error)
    );

    function automatic logic [7:0] core_byte(input int a);
        return 8'(a) ^ 8'(a >> 8) ^ 8'h5A;
    endfunction

    // Core memory: data is valid only during the second cycle after the strobe, garbage otherwise
    always @(negedge clk) begin
        if (rd_stage == 1) ioctl_din = core_byte(int'(rd_addr_q));
        else ioctl_din = ~core_byte(int'(rd_addr_q));
        if (rd_stage != 0) rd_stage = rd_stage - 1;
        since_rd = since_rd + 1;
        if (ioctl_rd === 1'b1) begin
            if (rd_count > 0 && since_rd < 31) spacing_bad = spacing_bad + 1;
            rd_addr_q = ioctl_addr;
            rd_stage  = 2;
            rd_count  = rd_count + 1;
            since_rd  = 0;
        end
    end

    task automatic push_expect(input int len);
        int n;
        n = ((len + 511) / 512) * 512;
        for (int i = 0; i < n; i++) exp_q.push_back((i < len) ? core_byte(i) : PAD);
    endtask

    task automatic mount(input int s, input logic [31:0] size);
        @(negedge clk);
        sd_img_mounted = 5'(1 << s);
        sd_img_size    = size;
        @(negedge clk);
        sd_img_mounted = 5'd0;
    endtask

    task automatic start_save(input logic [2:0] s, input int len);
        @(negedge clk);
        save_slot = s;
        save_len  = 23'(len);
        save_req  = 1'b1;
        @(negedge clk);
        save_req  = 1'b0;
    endtask

    // 0 = budget expired, 1 = sd_wr request, 2 = save_done, 3 = save_error
    task automatic wait_evt(input int budget, output int what);
        what = 0;
        for (int c = 0; c < budget && what == 0; c++) begin
            @(negedge clk);
            if (sd_wr !== 4'b0000) what = 1;
            else if (save_done === 1'b1) what = 2;
            else if (save_error === 1'b1) what = 3;
        end
    endtask

    task automatic serve_sector(input logic [3:0] exp_wr, input logic [31:0] exp_lba, input bit early_done);
        logic [7:0] e;
        checks++;
        if (sd_wr !== exp_wr) begin errors++; $display("FAIL sd_wr_mask got %b exp %b", sd_wr, exp_wr); end
        checks++;
        if (sd_lba !== exp_lba) begin errors++; $display("FAIL sd_lba got %0d exp %0d", sd_lba, exp_lba); end
        if (early_done) begin
            sd_done = 1'b1;
            @(negedge clk);
            sd_done = 1'b0;
            @(negedge clk);
            checks++;
            if (sd_wr !== exp_wr) begin errors++; $display("FAIL early_done_ignored got %b exp %b", sd_wr, exp_wr); end
        end
        sd_busy = 1'b1;
        #1;
        checks++;
        if (sd_wr !== 4'b0000) begin errors++; $display("FAIL sd_wr_clear got %b exp 0000", sd_wr); end
        for (int i = 0; i < 512; i++) begin
            sd_byte_index = 9'(i);
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty idx %0d got %h exp none", i, sd_wr_data);
            end else begin
                e = exp_q.pop_front();
                if (sd_wr_data !== e) begin
                    errors++;
                    $display("FAIL sector_byte lba %0d idx %0d got %h exp %h", exp_lba, i, sd_wr_data, e);
                end
            end
        end
        sd_busy = 1'b0;
        sd_done = 1'b1;
        @(negedge clk);
        sd_done = 1'b0;
    endtask

    task automatic run_to_end(input logic [3:0] exp_wr, input bit early_done, output int nsec, output int ending);
        int w;
        bit fin;
        nsec = 0;
        ending = 0;
        fin = 0;
        while (!fin) begin
            wait_evt(20000, w);
            if (w == 1 && nsec < 4) begin
                serve_sector(exp_wr, 32'(nsec), early_done);
                nsec++;
            end else begin
                ending = w;
                fin = 1;
            end
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({sd_wr, sd_lba} !== 36'd0) begin errors++; $display("FAIL reset_sd got %h exp 0", {sd_wr, sd_lba}); end
        checks++;
        if ({ioctl_upload, ioctl_rd, ioctl_addr} !== 25'd0) begin
            errors++; $display("FAIL reset_ioctl got %h exp 0", {ioctl_upload, ioctl_rd, ioctl_addr});
        end
        checks++;
        if ({saver_busy, save_done, save_error, sd_wr_data} !== 11'd0) begin
            errors++; $display("FAIL reset_status got %h exp 0", {saver_busy, save_done, save_error, sd_wr_data});
        end
        system_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reject;
        logic [2:0] rs [5];
        int rl [5];
        int bad;
        rs = '{3'd0, 3'd4, 3'd2, 3'd2, 3'd5};
        rl = '{10, 10, 1025, 0, 10};
        mount(0, 32'd4096);
        mount(1, 32'd2048);
        mount(2, 32'd1024);
        mount(3, 32'd4096);
        for (int k = 0; k < 5; k++) begin
            start_save(rs[k], rl[k]);
            checks++;
            if (save_error !== 1'b1) begin errors++; $display("FAIL reject_pulse case %0d got %b exp 1", k, save_error); end
            bad = 0;
            repeat (10) begin
                @(negedge clk);
                if (sd_wr !== 4'b0 || ioctl_upload !== 1'b0 || saver_busy !== 1'b0 || save_error !== 1'b0) bad++;
            end
            checks++;
            if (bad != 0) begin errors++; $display("FAIL reject_quiet case %0d got %0d exp 0", k, bad); end
        end
    endtask

    task automatic test_save_700;
        int nsec, ending;
        exp_q.delete();
        push_expect(700);
        rd_count = 0;
        spacing_bad = 0;
        start_save(3'd2, 700);
        checks++;
        if ({saver_busy, ioctl_upload} !== 2'b11) begin
            errors++; $display("FAIL accept_flags got %b exp 11", {saver_busy, ioctl_upload});
        end
        start_save(3'd0, 5);
        checks++;
        if ({save_error, saver_busy} !== 2'b01) begin
            errors++; $display("FAIL req_while_busy got %b exp 01", {save_error, saver_busy});
        end
        run_to_end(4'b0010, 1'b0, nsec, ending);
        checks++;
        if (nsec != 2) begin errors++; $display("FAIL s700_sectors got %0d exp 2", nsec); end
        checks++;
        if (ending != 2) begin errors++; $display("FAIL s700_done got %0d exp 2", ending); end
        checks++;
        if ({saver_busy, ioctl_upload} !== 2'b00) begin
            errors++; $display("FAIL s700_release got %b exp 00", {saver_busy, ioctl_upload});
        end
        checks++;
        if (rd_count != 700) begin errors++; $display("FAIL s700_reads got %0d exp 700", rd_count); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL s700_left got %0d exp 0", exp_q.size()); end
        checks++;
        if (spacing_bad != 0) begin errors++; $display("FAIL rd_spacing got %0d exp 0", spacing_bad); end
        @(negedge clk);
        checks++;
        if (save_done !== 1'b0) begin errors++; $display("FAIL done_one_cycle got %b exp 0", save_done); end
    endtask

    task automatic test_save_512;
        int nsec, ending;
        exp_q.delete();
        push_expect(512);
        rd_count = 0;
        start_save(3'd3, 512);
        run_to_end(4'b0100, 1'b1, nsec, ending);
        checks++;
        if (nsec != 1) begin errors++; $display("FAIL s512_sectors got %0d exp 1", nsec); end
        checks++;
        if (ending != 2) begin errors++; $display("FAIL s512_done got %0d exp 2", ending); end
        checks++;
        if (ioctl_addr !== 23'd512) begin errors++; $display("FAIL s512_addr got %0d exp 512", ioctl_addr); end
        checks++;
        if (rd_count != 512) begin errors++; $display("FAIL s512_reads got %0d exp 512", rd_count); end
    endtask

    task automatic test_stall_remount;
        int c, w, snap, bad;
        exp_q.delete();
        push_expect(600);
        rd_count = 0;
        start_save(3'd1, 600);
        c = 0;
        while (rd_count < 10 && c < 1000) begin @(negedge clk); c++; end
        checks++;
        if (rd_count < 10) begin errors++; $display("FAIL stall_prefill got %0d exp 10", rd_count); end
        ioctl_wait = 1'b1;
        @(negedge clk);
        snap = rd_count;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (ioctl_rd !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL rd_during_wait got %0d exp 0", bad); end
        checks++;
        if (rd_count != snap) begin errors++; $display("FAIL stall_reads got %0d exp %0d", rd_count, snap); end
        ioctl_wait = 1'b0;
        wait_evt(20000, w);
        checks++;
        if (w != 1) begin errors++; $display("FAIL stall_sector got %0d exp 1", w); end
        if (w == 1) begin
            mount(1, 32'd512);
            serve_sector(4'b0001, 32'd0, 1'b0);
        end
        wait_evt(100, w);
        checks++;
        if (w != 3) begin errors++; $display("FAIL remount_abort got %0d exp 3", w); end
        checks++;
        if ({saver_busy, ioctl_upload, sd_wr} !== 6'd0) begin
            errors++; $display("FAIL abort_release got %b exp 0", {saver_busy, ioctl_upload, sd_wr});
        end
        checks++;
        if (exp_q.size() != 512) begin errors++; $display("FAIL abort_left got %0d exp 512", exp_q.size()); end
        exp_q.delete();
    endtask

    task automatic test_reset_mid_save;
        int w, nsec, ending;
        exp_q.delete();
        push_expect(10);
        start_save(3'd2, 10);
        wait_evt(2000, w);
        checks++;
        if (w != 1) begin errors++; $display("FAIL rst_sector got %0d exp 1", w); end
        sd_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sd_byte_index = 9'(i);
            @(negedge clk);
        end
        system_reset = 1'b1;
        #1;
        checks++;
        if ({sd_wr, sd_lba, sd_wr_data} !== 44'd0) begin
            errors++; $display("FAIL rst_sd got %h exp 0", {sd_wr, sd_lba, sd_wr_data});
        end
        checks++;
        if ({ioctl_upload, ioctl_rd, ioctl_addr, saver_busy, save_done, save_error} !== 28'd0) begin
            errors++; $display("FAIL rst_ctrl got %h exp 0", {ioctl_upload, ioctl_rd, ioctl_addr, saver_busy, save_done, save_error});
        end
        sd_busy = 1'b0;
        sd_byte_index = 9'd0;
        repeat (2) @(negedge clk);
        system_reset = 1'b0;
        exp_q.delete();
        start_save(3'd2, 10);
        checks++;
        if (save_error !== 1'b1) begin errors++; $display("FAIL rst_table_cleared got %b exp 1", save_error); end
        mount(2, 32'd1024);
        push_expect(10);
        rd_count = 0;
        start_save(3'd2, 10);
        checks++;
        if (saver_busy !== 1'b1) begin errors++; $display("FAIL rst_reaccept got %b exp 1", saver_busy); end
        run_to_end(4'b0010, 1'b0, nsec, ending);
        checks++;
        if (nsec != 1 || ending != 2) begin
            errors++; $display("FAIL rst_resave got %0d/%0d exp 1/2", nsec, ending);
        end
        checks++;
        if (rd_count != 10) begin errors++; $display("FAIL rst_reads got %0d exp 10", rd_count); end
    endtask

`ifdef SAVE_SD_TIMEOUT_EN
    task automatic test_timeout;
        int w, c;
        exp_q.delete();
        start_save(3'd2, 10);
        wait_evt(2000, w);
        checks++;
        if (w != 1) begin errors++; $display("FAIL to_sector got %0d exp 1", w); end
        c = 0;
        while (save_error !== 1'b1 && c < 2000) begin @(negedge clk); c++; end
        checks++;
        if (c < 998 || c > 1002) begin errors++; $display("FAIL to_cycles got %0d exp 1000", c); end
        checks++;
        if ({ioctl_upload, saver_busy, sd_wr} !== 6'd0) begin
            errors++; $display("FAIL to_release got %b exp 0", {ioctl_upload, saver_busy, sd_wr});
        end
    endtask
`endif

    initial begin
        system_reset   = 1'b1;
        save_req       = 1'b0;
        save_slot      = 3'd0;
        save_len       = 23'd0;
        sd_img_mounted = 5'd0;
        sd_img_size    = 32'd0;
        sd_busy        = 1'b0;
        sd_byte_index  = 9'd0;
        sd_done        = 1'b0;
        ioctl_wait     = 1'b0;
        test_reset();
        test_reject();
        test_save_700();
        test_save_512();
        test_stall_remount();
        test_reset_mid_save();
`ifdef SAVE_SD_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
